// File: rtl/cic_decimator.sv
// cic_decimator: N-stage CIC decimator (differential delay 1), decimation by R.
// Integrators run on every accepted input sample; the comb section is a
// pipeline that advances one stage per cycle behind each decimation strobe.
// Optional macro CIC_ROUND_EN: round half up (with positive saturation) before
// taking the top O_WIDTH bits; when undefined the output is a plain floor slice.
module cic_decimator #(
    parameter int I_WIDTH = 16,
    parameter int O_WIDTH = 16,
    parameter int N       = 3,
    parameter int R       = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic [I_WIDTH-1:0] data_i,
    output logic               valid_o,
    output logic [O_WIDTH-1:0] data_o
);

    localparam int G  = I_WIDTH + N * $clog2(R);
    localparam int CW = (R > 1) ? $clog2(R) : 1;
    localparam int S  = G - O_WIDTH;

    logic [N-1:0][G-1:0] int_q;
    logic [G-1:0]        din_sext;
    logic [CW-1:0]       cnt_q;
    logic                dec_stb_q;
    logic [G-1:0]        dec_q;
    logic [N-1:0][G-1:0] comb_q;
    logic [N-1:0][G-1:0] dly_q;
    logic [N-1:0][G-1:0] comb_in;
    logic [N:0]          vld_pipe_q;
    logic [O_WIDTH-1:0]  slice_d;
    logic [O_WIDTH-1:0]  data_q;
    logic                valid_q;

    assign din_sext = G'(signed'(data_i));

    // Integrator chain: each stage accumulates the previous stage's registered
    // value, wrapping modulo 2^G (the combs undo the wrap).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            int_q <= '0;
        end else if (valid_i) begin
            int_q[0] <= int_q[0] + din_sext;
            for (int k = 1; k < N; k++)
                int_q[k] <= int_q[k] + int_q[k-1];
        end
    end

    // Decimation counter: counts accepted samples, strobes on the R-th one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            dec_stb_q <= 1'b0;
        end else begin
            dec_stb_q <= valid_i && (cnt_q == CW'(R - 1));
            if (valid_i)
                cnt_q <= (cnt_q == CW'(R - 1)) ? '0 : cnt_q + CW'(1);
        end
    end

    // Decimation register and comb-valid shift register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dec_q      <= '0;
            vld_pipe_q <= '0;
        end else begin
            if (dec_stb_q)
                dec_q <= int_q[N-1];
            vld_pipe_q <= {vld_pipe_q[N-1:0], dec_stb_q};
        end
    end

    // Comb stage inputs: stage 0 reads the decimation register, others chain.
    always_comb begin
        comb_in    = '0;
        comb_in[0] = dec_q;
        for (int k = 1; k < N; k++)
            comb_in[k] = comb_q[k-1];
    end

    // Comb pipeline: each stage differences its input against the previous
    // decimated input, only when its own valid bit is set.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            comb_q <= '0;
            dly_q  <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (vld_pipe_q[k]) begin
                    comb_q[k] <= comb_in[k] - dly_q[k];
                    dly_q[k]  <= comb_in[k];
                end
            end
        end
    end

`ifdef CIC_ROUND_EN
    generate
        if (S > 0) begin : g_round
            localparam logic [G:0] HALF = (G+1)'(1) << (S - 1);
            logic [G:0] rnd_sum;
            assign rnd_sum = {comb_q[N-1][G-1], comb_q[N-1]} + HALF;
            // Adding a positive half can only overflow upward; clamp to max.
            assign slice_d = (rnd_sum[G:G-1] == 2'b01) ? {1'b0, {(O_WIDTH-1){1'b1}}}
                                                       : rnd_sum[G-1:S];
        end else begin : g_noround
            assign slice_d = comb_q[N-1];
        end
    endgenerate
`else
    assign slice_d = comb_q[N-1][G-1 -: O_WIDTH];
`endif

    // Output register: update data and pulse valid when the last comb finishes.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= vld_pipe_q[N];
            if (vld_pipe_q[N])
                data_q <= slice_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_cic_decimator.sv
// tb_cic_decimator: randomized-gap bench for cic_decimator (16- and 8-bit
// output instances side by side) against a sample-level arithmetic model.
module tb_cic_decimator;

    localparam int IW = 16;
    localparam int N  = 3;
    localparam int R  = 8;
    localparam int G  = IW + N * $clog2(R);

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [15:0] data_i;
    logic        vo16, vo8;
    logic [15:0] do16;
    logic [7:0]  do8;

    always #5 clk = ~clk;

    cic_decimator #(.I_WIDTH(16), .O_WIDTH(16), .N(N), .R(R)) u16 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .data_i(data_i),
        .valid_o(vo16), .data_o(do16));

    cic_decimator #(.I_WIDTH(16), .O_WIDTH(8), .N(N), .R(R)) u8 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .data_i(data_i),
        .valid_o(vo8), .data_o(do8));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic longint wrapg(input longint x);
        longint m;
        m = longint'(1) << G;
        x = x & (m - 1);
        if (x >= (m >>> 1)) x = x - m;
        return x;
    endfunction

    // Full-precision G-bit result reduced to ow bits.
    function automatic longint slice(input longint c, input int ow);
        int s;
        longint t;
        s = G - ow;
        t = c;
`ifdef CIC_ROUND_EN
        if (s > 0) begin
            t = c + (longint'(1) << (s - 1));
            if (t >= (longint'(1) << (G - 1)))
                return (longint'(1) << (ow - 1)) - 1;
        end
`endif
        return t >>> s;
    endfunction

    // Reference model state
    longint integ[N];
    longint dly[N];
    int     mcnt;
    longint q16[$];
    longint q8[$];
    int     qcyc[$];
    longint last16 = 0, last8 = 0;
    int     cyc = 0;

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            integ[k] = 0;
            dly[k]   = 0;
        end
        mcnt = 0;
        q16.delete();
        q8.delete();
        qcyc.delete();
    endtask

    // Monitor at negedge: check outputs from the last posedge, then fold in
    // the input that the next posedge will accept.
    initial begin
        longint x, y, e16, e8;
        int ec;
        model_clear();
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                model_clear();
            end else begin
                if (vo16 || vo8) begin
                    if (q16.size() == 0) begin
                        chk("unexpected_valid", 1, 0);
                    end else begin
                        e16 = q16.pop_front();
                        e8  = q8.pop_front();
                        ec  = qcyc.pop_front();
                        chk("latency", cyc, ec);
                        chk("vo16", vo16, 1);
                        chk("vo8", vo8, 1);
                        chk("do16", longint'($signed(do16)), e16);
                        chk("do8", longint'($signed(do8)), e8);
                        last16 = $signed(do16);
                        last8  = $signed(do8);
                    end
                end else if (qcyc.size() > 0 && qcyc[0] < cyc) begin
                    chk("missing_valid", 0, 1);
                    void'(q16.pop_front());
                    void'(q8.pop_front());
                    void'(qcyc.pop_front());
                end
                if (valid_i === 1'b1) begin
                    for (int k = N - 1; k > 0; k--)
                        integ[k] = wrapg(integ[k] + integ[k-1]);
                    integ[0] = wrapg(integ[0] + longint'($signed(data_i)));
                    if (mcnt == R - 1) begin
                        mcnt = 0;
                        x = integ[N-1];
                        for (int k = 0; k < N; k++) begin
                            y = wrapg(x - dly[k]);
                            dly[k] = x;
                            x = y;
                        end
                        q16.push_back(slice(x, 16));
                        q8.push_back(slice(x, 8));
                        qcyc.push_back(cyc + 1 + N + 2);
                    end else begin
                        mcnt++;
                    end
                end
            end
        end
    end

    // mode: 0 continuous, 1 one valid in three, 2 random gaps; rnd: random data
    task automatic feed(input int n, input int mode, input bit rnd, input logic [15:0] d);
        int gap;
        for (int i = 0; i < n; i++) begin
            gap = (mode == 0) ? 0 : (mode == 1) ? 2 : int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                valid_i = 1'b0;
                data_i  = 16'($urandom);
            end
            @(posedge clk); #1;
            valid_i = 1'b1;
            data_i  = rnd ? 16'($urandom) : d;
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic drain();
        repeat (N + 6) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        valid_i = 1'b0;
        #1;
        chk("rst_do16", do16, 0);
        chk("rst_vo16", vo16, 0);
        chk("rst_do8", do8, 0);
        chk("rst_vo8", vo8, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    longint exp8_1000;

    initial begin
`ifdef CIC_ROUND_EN
        exp8_1000 = 4;
`else
        exp8_1000 = 3;
`endif
        rst = 1'b1;
        valid_i = 1'b0;
        data_i = '0;
        #1;
        chk("init_do16", do16, 0);
        chk("init_vo16", vo16, 0);
        chk("init_do8", do8, 0);
        chk("init_vo8", vo8, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Continuous DC input
        feed(64, 0, 1'b0, 16'd1000);
        drain();
        chk("dc_cont16", last16, 1000);
        chk("dc_cont8", last8, exp8_1000);

        // Sparse DC input from a fresh start
        pulse_reset();
        feed(64, 1, 1'b0, 16'd1000);
        drain();
        chk("dc_sparse16", last16, 1000);
        chk("dc_sparse8", last8, exp8_1000);

        // Full-scale extremes with random gaps
        feed(64, 2, 1'b0, 16'h8000);
        drain();
        chk("neg_fs16", last16, -32768);
        chk("neg_fs8", last8, -128);
        feed(64, 2, 1'b0, 16'h7fff);
        drain();
        chk("pos_fs16", last16, 32767);
        chk("pos_fs8", last8, 127);

        // Reset in mid-flight after 5 samples, then fresh DC run
        feed(5, 0, 1'b0, 16'd1000);
        pulse_reset();
        feed(40, 0, 1'b0, 16'd1000);
        drain();
        chk("post_rst16", last16, 1000);

        // Random data, random gaps
        feed(200, 2, 1'b1, 16'd0);
        drain();
        feed(100, 0, 1'b1, 16'd0);
        drain();

        chk("drained", q16.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
